// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM state
// encodings and the CLAIM valid-bit position.
package irq_ctrl_pkg;

   localparam logic [2:0] REG_PEND   = 3'd0;
   localparam logic [2:0] REG_MASK   = 3'd1;
   localparam logic [2:0] REG_MODE   = 3'd2;
   localparam logic [2:0] REG_CLAIM  = 3'd3;
   localparam logic [2:0] REG_EOI    = 3'd4;
   localparam logic [2:0] REG_STATUS = 3'd5;

   localparam int CLAIM_VALID_BIT = 31;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      ACTIVE = 2'd2
   } irqState_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder: source 0 is the highest priority.
module irq_prio_enc #(
   parameter int N_SRC = 6,
   parameter int ID_W  = 5
) (
   input  logic [N_SRC-1:0] req,
   output logic             valid,
   output logic [ID_W-1:0]  id
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      valid = 1'b0;
      id    = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            id    = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller with per-source level/edge capture, masking,
// fixed priority and a claim/EOI handshake. Optional input sync: IRQ_CTRL_SYNC_EN.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int N_SRC = 6,
   parameter int ID_W  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sel,
   input  logic             we,
   input  logic [2:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [N_SRC-1:0] irq_in,
   output logic             irq_out
);

   logic [N_SRC-1:0] syncIrq;
   logic [N_SRC-1:0] prevIrq;
   logic [N_SRC-1:0] edgePend;
   logic [N_SRC-1:0] maskReg;
   logic [N_SRC-1:0] modeReg;
   logic [N_SRC-1:0] pendVec;
   logic [N_SRC-1:0] pendMasked;
   logic [N_SRC-1:0] riseVec;
   logic [N_SRC-1:0] w1cClr;
   logic [N_SRC-1:0] claimClr;
   logic             winValid;
   logic [ID_W-1:0]  winId;
   logic [ID_W-1:0]  claimedId;
   irqState_t        state;
   irqState_t        stateNext;
   logic             irqOut;
   logic             pendWrite;
   logic             maskWrite;
   logic             modeWrite;
   logic             eoiWrite;
   logic             claimRead;
   logic             claimTake;
   logic             unusedWdata;

`ifdef IRQ_CTRL_SYNC_EN
   logic [N_SRC-1:0] syncStage1;
   logic [N_SRC-1:0] syncStage2;

   always_ff @(posedge clk) begin
      if (reset) begin
         syncStage1 <= '0;
         syncStage2 <= '0;
      end else begin
         syncStage1 <= irq_in;
         syncStage2 <= syncStage1;
      end
   end

   assign syncIrq = syncStage2;
`else
   assign syncIrq = irq_in;
`endif

   assign pendWrite = sel && we && (addr == REG_PEND);
   assign maskWrite = sel && we && (addr == REG_MASK);
   assign modeWrite = sel && we && (addr == REG_MODE);
   assign eoiWrite  = sel && we && (addr == REG_EOI);
   assign claimRead = sel && !we && (addr == REG_CLAIM);
   assign claimTake = claimRead && (state == PEND) && winValid;

   assign unusedWdata = ^wdata;

   assign riseVec    = syncIrq & ~prevIrq & modeReg;
   assign w1cClr     = pendWrite ? (wdata[N_SRC-1:0] & modeReg) : '0;
   assign pendVec    = (edgePend & modeReg) | (syncIrq & ~modeReg);
   assign pendMasked = pendVec & maskReg;

   always_comb begin
      claimClr = '0;
      for (int i = 0; i < N_SRC; i++) begin
         claimClr[i] = claimTake && (winId == ID_W'(i));
      end
   end

   irq_prio_enc #(
      .N_SRC (N_SRC),
      .ID_W  (ID_W)
   ) u_prio (
      .req   (pendMasked),
      .valid (winValid),
      .id    (winId)
   );

   // Tracks the source level even during reset so a line already high at release is not an edge.
   always_ff @(posedge clk) begin
      prevIrq <= syncIrq;
   end

   // A fresh rising edge outranks a same-cycle W1C or claim clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         edgePend <= '0;
         maskReg  <= '0;
         modeReg  <= '0;
      end else begin
         edgePend <= (edgePend & ~w1cClr & ~claimClr) | riseVec;
         if (maskWrite) maskReg <= wdata[N_SRC-1:0];
         if (modeWrite) modeReg <= wdata[N_SRC-1:0];
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (|pendMasked) stateNext = PEND;
         end
         PEND: begin
            if (claimTake)             stateNext = ACTIVE;
            else if (!(|pendMasked))   stateNext = IDLE;
         end
         ACTIVE: begin
            if (eoiWrite && (wdata[ID_W-1:0] == claimedId)) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // irq_out rises a cycle after entering PEND and drops on the very edge that leaves it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         irqOut    <= 1'b0;
         claimedId <= '0;
      end else begin
         state  <= stateNext;
         irqOut <= (state == PEND) && (stateNext == PEND);
         if (claimTake) claimedId <= winId;
      end
   end

   assign irq_out = irqOut;

   always_comb begin
      rdata = '0;
      case (addr)
         REG_PEND:   rdata[N_SRC-1:0] = pendVec;
         REG_MASK:   rdata[N_SRC-1:0] = maskReg;
         REG_MODE:   rdata[N_SRC-1:0] = modeReg;
         REG_CLAIM: begin
            if ((state == PEND) && winValid) begin
               rdata[CLAIM_VALID_BIT] = 1'b1;
               rdata[ID_W-1:0]        = winId;
            end
         end
         REG_STATUS: begin
            rdata[9:8]      = state;
            rdata[ID_W-1:0] = claimedId;
         end
         default:    rdata = '0;
      endcase
   end

endmodule
